// File: rtl/aes_wb_seq.sv
// Writes a 128-bit AES result into four consecutive register-file entries,
// yielding the write port to the pipeline writeback stage whenever it asks for it.
module aes_wb_seq (
    input  logic         in_clk,
    input  logic         in_rst,
    input  logic         in_aes_done,
    input  logic [127:0] in_aes_result,
    input  logic [4:0]   in_base_addr,
    input  logic         in_wb_regWrite,
    input  logic [4:0]   in_wb_rd_addr,
    input  logic [31:0]  in_wb_data,
    output logic         out_regWrite,
    output logic [4:0]   out_w_rd_addr,
    output logic [31:0]  out_write_data,
    output logic         out_busy,
    output logic         out_done,
    output logic         out_overrun
);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t       state, state_nxt;
    logic [1:0]   cnt, cnt_nxt;
    logic [127:0] blk_buf;
    logic [4:0]   base_addr;
    logic         overrun;
    logic         capture;
    logic [4:0]   seq_addr;
    logic [31:0]  seq_word;

    // Word 0 is the most significant 32 bits of the block.
    function automatic logic [31:0] pick_word(input logic [127:0] blk, input logic [1:0] k);
        logic [31:0] w;
        case (k)
            2'd0:    w = blk[127:96];
            2'd1:    w = blk[95:64];
            2'd2:    w = blk[63:32];
            default: w = blk[31:0];
        endcase
        return w;
    endfunction

    // 5-bit sum wraps naturally past register 31.
    assign seq_addr = base_addr + {3'b000, cnt};
    assign seq_word = pick_word(blk_buf, cnt);

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        capture        = 1'b0;
        out_regWrite   = 1'b0;
        out_w_rd_addr  = 5'd0;
        out_write_data = 32'd0;
        case (state)
            IDLE: begin
                if (in_aes_done) begin
                    state_nxt = WRITE;
                    cnt_nxt   = 2'd0;
                    capture   = 1'b1;
                end
            end
            WRITE: begin
                if (!in_wb_regWrite) begin
                    // A word aimed at $0 still consumes its slot but is not written.
                    out_regWrite   = (seq_addr != 5'd0);
                    out_w_rd_addr  = seq_addr;
                    out_write_data = seq_word;
                    cnt_nxt        = cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (in_wb_regWrite) begin
            out_regWrite   = 1'b1;
            out_w_rd_addr  = in_wb_rd_addr;
            out_write_data = in_wb_data;
        end
    end

    assign out_busy    = (state == WRITE) || (state == DONE);
    assign out_done    = (state == DONE);
    assign out_overrun = overrun;

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            blk_buf   <= 128'd0;
            base_addr <= 5'd0;
            overrun   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (capture) begin
                blk_buf   <= in_aes_result;
                base_addr <= in_base_addr;
            end
            if (in_aes_done && (state != IDLE)) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_aes_wb_seq.sv
// Scoreboard bench for aes_wb_seq: stimulus pushes the expected per-cycle port
// activity, a negedge monitor pops and compares whenever the port is active.
module tb_aes_wb_seq;

    logic         in_clk = 1'b0;
    logic         in_rst;
    logic         in_aes_done;
    logic [127:0] in_aes_result;
    logic [4:0]   in_base_addr;
    logic         in_wb_regWrite;
    logic [4:0]   in_wb_rd_addr;
    logic [31:0]  in_wb_data;
    logic         out_regWrite;
    logic [4:0]   out_w_rd_addr;
    logic [31:0]  out_write_data;
    logic         out_busy;
    logic         out_done;
    logic         out_overrun;

    aes_wb_seq dut (
        .in_clk(in_clk), .in_rst(in_rst), .in_aes_done(in_aes_done),
        .in_aes_result(in_aes_result), .in_base_addr(in_base_addr),
        .in_wb_regWrite(in_wb_regWrite), .in_wb_rd_addr(in_wb_rd_addr),
        .in_wb_data(in_wb_data), .out_regWrite(out_regWrite),
        .out_w_rd_addr(out_w_rd_addr), .out_write_data(out_write_data),
        .out_busy(out_busy), .out_done(out_done), .out_overrun(out_overrun)
    );

    always #5 in_clk = ~in_clk;

    typedef struct packed {
        logic        we;
        logic [4:0]  a;
        logic [31:0] d;
        logic        dn;
        logic        bz;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_pops   = 0;
    bit   mon_en   = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, req);
    endtask

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    task automatic push(input logic we, input logic [4:0] a, input logic [31:0] d,
                        input logic dn, input logic bz);
        exp_t e;
        e.we = we; e.a = a; e.d = d; e.dn = dn; e.bz = bz;
        exp_q.push_back(e);
    endtask

    task automatic start(input logic [4:0] base, input logic [127:0] res);
        in_aes_done   = 1'b1;
        in_base_addr  = base;
        in_aes_result = res;
        tick();
        in_aes_done   = 1'b0;
    endtask

    // Four uninterrupted word cycles (T+1..T+4); caller handles the DONE cycle.
    task automatic words(input logic [4:0] base, input logic [127:0] res);
        logic [4:0]  a;
        logic [31:0] w;
        for (int k = 0; k < 4; k++) begin
            a = base + 5'(k);
            w = res[127-32*k -: 32];
            push(a != 5'd0, a, w, 1'b0, 1'b1);
            tick();
        end
    endtask

    task automatic done_cycle();
        push(1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
        tick();
    endtask

    // Monitor: active cycles must match the scoreboard head; idle cycles must be quiet.
    always @(negedge in_clk) begin
        exp_t act;
        exp_t req;
        if (mon_en) begin
            act = {out_regWrite, out_w_rd_addr, out_write_data, out_done, out_busy};
            if (out_regWrite === 1'b1 || out_busy === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_activity", 128'(act), 128'(0));
                end else begin
                    req = exp_q.pop_front();
                    chk($sformatf("cycle_%0d", n_pops), 128'(act), 128'(req));
                    n_pops++;
                end
            end else begin
                chk("idle_outputs", {out_w_rd_addr, out_write_data, out_done},
                    128'd0);
            end
        end
    end

    initial begin
        logic [127:0] r;
        in_rst = 1'b1; in_aes_done = 1'b0; in_aes_result = '0; in_base_addr = '0;
        in_wb_regWrite = 1'b0; in_wb_rd_addr = '0; in_wb_data = '0;
        tick(); tick();
        in_rst = 1'b0;
        mon_en = 1'b1;
        chk("reset_state", {out_busy, out_done, out_regWrite, out_overrun}, 128'd0);
        tick();

        // Basic block
        r = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        start(5'd8, r);
        words(5'd8, r);
        done_cycle();
        tick();

        // Pipeline write while idle is forwarded
        in_wb_regWrite = 1'b1; in_wb_rd_addr = 5'd7; in_wb_data = 32'h5A5A5A5A;
        push(1'b1, 5'd7, 32'h5A5A5A5A, 1'b0, 1'b0);
        tick();
        in_wb_regWrite = 1'b0;
        tick();

        // Pipeline conflict at T+2
        r = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
        start(5'd12, r);
        push(1'b1, 5'd12, 32'h01234567, 1'b0, 1'b1);
        tick();
        in_wb_regWrite = 1'b1; in_wb_rd_addr = 5'd5; in_wb_data = 32'hDEADBEEF;
        push(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b1);
        tick();
        in_wb_regWrite = 1'b0;
        push(1'b1, 5'd13, 32'h89ABCDEF, 1'b0, 1'b1); tick();
        push(1'b1, 5'd14, 32'hFEDCBA98, 1'b0, 1'b1); tick();
        push(1'b1, 5'd15, 32'h76543210, 1'b0, 1'b1); tick();
        done_cycle();
        tick();

        // Address wrap and suppressed write to $0
        r = 128'hAAAA0001_BBBB0002_CCCC0003_DDDD0004;
        start(5'd30, r);
        push(1'b1, 5'd30, 32'hAAAA0001, 1'b0, 1'b1); tick();
        push(1'b1, 5'd31, 32'hBBBB0002, 1'b0, 1'b1); tick();
        push(1'b0, 5'd0,  32'hCCCC0003, 1'b0, 1'b1); tick();
        push(1'b1, 5'd1,  32'hDDDD0004, 1'b0, 1'b1); tick();
        done_cycle();
        tick();
        chk("overrun_clear_before", 128'(out_overrun), 128'd0);

        // Overrun: second done at T+2 is ignored
        r = 128'h11111111_22222222_33333333_44444444;
        start(5'd4, r);
        push(1'b1, 5'd4, 32'h11111111, 1'b0, 1'b1); tick();
        in_aes_done = 1'b1; in_base_addr = 5'd20; in_aes_result = {4{32'hFFFFFFFF}};
        push(1'b1, 5'd5, 32'h22222222, 1'b0, 1'b1); tick();
        in_aes_done = 1'b0;
        chk("overrun_set", 128'(out_overrun), 128'd1);
        push(1'b1, 5'd6, 32'h33333333, 1'b0, 1'b1); tick();
        push(1'b1, 5'd7, 32'h44444444, 1'b0, 1'b1); tick();
        done_cycle();
        tick(); tick(); tick();
        chk("overrun_sticky", 128'(out_overrun), 128'd1);

        in_rst = 1'b1; tick(); in_rst = 1'b0;
        chk("overrun_reset", 128'(out_overrun), 128'd0);

        // Reset mid-block at T+2
        r = 128'h10101010_20202020_30303030_40404040;
        start(5'd16, r);
        push(1'b1, 5'd16, 32'h10101010, 1'b0, 1'b1); tick();
        in_rst = 1'b1;
        push(1'b1, 5'd17, 32'h20202020, 1'b0, 1'b1); tick();
        in_rst = 1'b0;
        chk("midreset_state", {out_busy, out_done, out_overrun}, 128'd0);
        tick(); tick(); tick(); tick(); tick();

        // Reset wins over a simultaneous capture
        in_rst = 1'b1; in_aes_done = 1'b1; in_base_addr = 5'd9; in_aes_result = r;
        tick();
        in_rst = 1'b0; in_aes_done = 1'b0;
        chk("reset_vs_done", {out_busy, out_overrun}, 128'd0);
        tick(); tick();

        // Back-to-back: capture in the IDLE cycle right after DONE
        r = 128'hCAFEF00D_0BADC0DE_12345678_9ABCDEF0;
        start(5'd2, r);
        words(5'd2, r);
        done_cycle();
        r = 128'h00000001_00000002_00000003_00000004;
        start(5'd24, r);
        words(5'd24, r);
        done_cycle();
        tick();
        chk("b2b_no_overrun", 128'(out_overrun), 128'd0);

        // Done arriving in the DONE cycle is an overrun, not a capture
        r = 128'hCAFEF00D_0BADC0DE_12345678_9ABCDEF0;
        start(5'd3, r);
        words(5'd3, r);
        in_aes_done = 1'b1; in_base_addr = 5'd10;
        done_cycle();
        in_aes_done = 1'b0;
        chk("done_cycle_overrun", {out_busy, out_overrun}, 128'd1);
        tick(); tick(); tick();

        chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/aes_wb_seq.md
AES_WB_SEQ -- requirements
Module: aes_wb_seq

Interface
REQ-001 The module SHALL have these ports:
- in_clk, input, 1: sole clock; all state updates on rising edge.
- in_rst, input, 1: synchronous, active-high reset.
- in_aes_done, input, 1: one-cycle pulse; in_aes_result is valid this cycle.
- in_aes_result, input, 128: AES output block.
- in_base_addr, input, 5: register index that receives the first result word.
- in_wb_regWrite, input, 1: pipeline WB stage requests the register-file write port.
- in_wb_rd_addr, input, 5: pipeline WB write address.
- in_wb_data, input, 32: pipeline WB write data.
- out_regWrite, output, 1: register-file write enable.
- out_w_rd_addr, output, 5: register-file write address.
- out_write_data, output, 32: register-file write data.
- out_busy, output, 1: a result block is pending or being written.
- out_done, output, 1: one-cycle pulse after the last word is written.
- out_overrun, output, 1: sticky flag; set when in_aes_done arrives while busy.

Function
REQ-002 States SHALL be IDLE, WRITE and DONE, with a 2-bit word counter cnt.
- IDLE -> WRITE on in_aes_done.
- WRITE -> DONE when the word at cnt=3 is issued.
- DONE -> IDLE unconditionally after one cycle.
REQ-003 In IDLE, in_aes_done=1 SHALL capture in_aes_result into a 128-bit buffer, capture in_base_addr, and clear cnt to 0.
REQ-004 Word k (k=0..3) SHALL be buffer[127-32k -: 32], so word0 is bits [127:96].
REQ-005 Word k SHALL be written to address (base+k) mod 32; the 5-bit address wraps (e.g. base 30 gives 30, 31, 0, 1).
REQ-006 The pipeline SHALL have priority for the write port:
- in_wb_regWrite=1 forwards in_wb_regWrite, in_wb_rd_addr and in_wb_data combinationally to the outputs, and cnt holds.
- in_wb_regWrite=0 in WRITE issues the sequencer word with out_regWrite=1 and increments cnt.
REQ-007 A sequencer word whose target address is 0 SHALL be issued with out_regWrite=0, and cnt SHALL still advance.
REQ-008 Outside WRITE with in_wb_regWrite=0, the outputs SHALL be: out_regWrite=0, out_w_rd_addr=0, out_write_data=0.
REQ-009 out_busy SHALL be 1 exactly in WRITE and DONE.
REQ-010 out_done SHALL be 1 exactly in DONE.
REQ-011 Best-case latency: in_aes_done at cycle T gives writes at T+1..T+4 and out_done at T+5; each cycle of pipeline priority adds one cycle.
REQ-012 in_aes_done while out_busy=1 SHALL be ignored (buffer unchanged) and SHALL set out_overrun.
REQ-013 out_overrun SHALL stay set until reset.
REQ-014 in_aes_done in the DONE cycle SHALL count as an overrun; a new capture is accepted only in IDLE.
REQ-015 The sequencer SHALL never drive two writes in one cycle, and SHALL never drop a pipeline write.

Reset
REQ-016 With in_rst=1 at a clock edge, the block SHALL enter IDLE with cnt=0, buffer=0, base=0 and out_overrun=0.
REQ-017 After that edge, out_busy, out_done and out_regWrite (absent a pipeline write) SHALL read 0.
REQ-018 Reset during WRITE SHALL abandon the remaining words; words already written are not undone.
REQ-019 Reset SHALL take priority over a simultaneous in_aes_done, and no capture occurs.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Basic block: base=8, result=0x00112233_44556677_8899AABB_CCDDEEFF, in_wb_regWrite=0 -> writes $8=0x00112233, $9=0x44556677, $10=0x8899AABB, $11=0xCCDDEEFF on T+1..T+4; out_done=1 at T+5 only.
- Pipeline conflict: in_wb_regWrite=1 (addr 5, data 0xDEADBEEF) at T+2 -> that cycle outputs addr 5/0xDEADBEEF; sequencer words land at T+1, T+3, T+4, T+5; out_done at T+6.
- Wrap and $0: base=30 -> writes to $30 and $31, a cycle with out_regWrite=0 at address 0, then $1; out_done at T+5.
- Overrun: second in_aes_done at T+2 -> buffer and write sequence unchanged; out_overrun=1 and stays 1 until in_rst.
- Reset mid-block: in_rst=1 at T+2 -> no writes from T+3 on; out_busy=0, out_done never pulses, out_overrun=0.
- Back-to-back: new in_aes_done in the IDLE cycle right after DONE -> accepted, out_overrun stays 0.
